skinny_masked_inv_sbox_iterative: RTL and testbench

Masked, iterative inverse of the SKINNY 8-bit S-box (S8⁻¹), built from d-share HPC2 AND gadgets with an on-board control FSM and valid/ready handshakes. It is the decryption-side counterpart to the forward serialized masked S-box. It uses the same share packing, so forward and inverse instances are interchangeable in a serialized SKINNY datapath. One byte is processed per transaction, with no unmasked intermediate ever formed.

---
 rtl/skinny_sbox_pkg.sv | 22 ++
 rtl/skinny_inv_sbox_round.sv | 73 +++++++
 rtl/skinny_masked_inv_sbox_iterative.sv | 118 +++++++++++
 tb/tb_skinny_masked_inv_sbox_iterative.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/skinny_sbox_pkg.sv
// Shared constants for the SKINNY 8-bit S-box datapaths: bit permutations,
// control FSM states and the per-round randomness budget.
package skinny_sbox_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ROUND,
    ST_DONE
  } state_e;

  // Entry i names the source bit that lands in destination bit i.
  localparam int unsigned P_FWD  [8] = '{5, 3, 0, 4, 6, 7, 1, 2};
  localparam int unsigned P_INV  [8] = '{2, 6, 7, 1, 3, 0, 4, 5};
  localparam int unsigned P3_FWD [8] = '{0, 2, 1, 3, 4, 5, 6, 7};
  localparam int unsigned P3_INV [8] = '{0, 2, 1, 3, 4, 5, 6, 7};

  // Two HPC2 gadgets per round, each needing one bit per share pair.
  function automatic int nrnd(input int d);
    return 2 * (d * (d - 1) / 2);
  endfunction

endpackage

// File: rtl/skinny_inv_sbox_round.sv
// Two masked NOR-XOR lanes of the S-box round: x4 ^= ~(x7|x6), x0 ^= ~(x3|x2),
// each built from an HPC2 AND of complemented operands. Registers load on en.
module skinny_inv_sbox_round
  import skinny_sbox_pkg::*;
#(
  parameter int d = 2,
  localparam int NRND = nrnd(d),
  localparam int NR = NRND / 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            en,
  input  logic            clr,
  input  logic [8*d-1:0]  state_in,
  input  logic [NRND-1:0] rnd,
  output logic [8*d-1:0]  state_out
);
  localparam int unsigned OPA [2] = '{7, 3};
  localparam int unsigned OPB [2] = '{6, 2};
  localparam logic [d-1:0] INV_MASK = 1;

  logic [2*d-1:0] nor_out;

  genvar gl, gi, gj;
  for (gl = 0; gl < 2; gl++) begin : g_lane
    logic [d-1:0] a, b, c;
    // Masked NOT only flips share 0.
    assign a = state_in[OPA[gl]*d +: d] ^ INV_MASK;
    assign b = state_in[OPB[gl]*d +: d] ^ INV_MASK;

    for (gi = 0; gi < d; gi++) begin : g_share
      logic ab_reg;
      logic [d-2:0] terms;

      always_ff @(posedge clk) begin
        if (!rst_n || clr) ab_reg <= 1'b0;
        else if (en)       ab_reg <= a[gi] & b[gi];
      end

      for (gj = 0; gj < d - 1; gj++) begin : g_pair
        localparam int J  = (gj < gi) ? gj : gj + 1;
        localparam int LO = (gi < J) ? gi : J;
        localparam int HI = (gi < J) ? J : gi;
        // r_ij is shared between share i and share j (symmetric pair index).
        localparam int K  = LO * d - LO * (LO + 1) / 2 + (HI - LO - 1);
        logic u_reg, v_reg;

        always_ff @(posedge clk) begin
          if (!rst_n || clr) begin
            u_reg <= 1'b0;
            v_reg <= 1'b0;
          end else if (en) begin
            u_reg <= ~a[gi] & rnd[gl*NR + K];
            v_reg <= b[J] ^ rnd[gl*NR + K];
          end
        end

        assign terms[gj] = u_reg ^ (a[gi] & v_reg);
      end

      assign c[gi] = ab_reg ^ (^terms);
    end

    assign nor_out[gl*d +: d] = c;
  end

  always_comb begin
    state_out          = state_in;
    state_out[4*d +: d] = state_in[4*d +: d] ^ nor_out[0 +: d];
    state_out[0 +: d]   = state_in[0 +: d] ^ nor_out[d +: d];
  end

endmodule

// File: rtl/skinny_masked_inv_sbox_iterative.sv
// Masked iterative SKINNY S8^-1: four rounds of (P_r^-1, f), two cycles each.
// Define INVSBOX_FLUSH_EN to clear state and gadget registers after each result.
`ifndef DEFAULTSHARES
`define DEFAULTSHARES 2
`endif

module skinny_masked_inv_sbox_iterative
  import skinny_sbox_pkg::*;
#(
  parameter int d = `DEFAULTSHARES,
  localparam int NRND = nrnd(d)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [8*d-1:0]  in_data,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [NRND-1:0] rnd,
  output logic [8*d-1:0]  out_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic            busy
);
  state_e         fsm_reg;
  logic [1:0]     rc_reg;
  logic           ph_reg;
  logic [8*d-1:0] state_reg;
  logic [8*d-1:0] in_perm;
  logic [8*d-1:0] round_out;
  logic [8*d-1:0] round_perm;
  logic           gadget_en;
  logic           gadget_clr;

  // Permutations are share-wise rewiring of whole bit groups.
  genvar gi;
  for (gi = 0; gi < 8; gi++) begin : g_perm
    assign in_perm[gi*d +: d]    = in_data[P3_INV[gi]*d +: d];
    assign round_perm[gi*d +: d] = round_out[P_INV[gi]*d +: d];
  end

  assign gadget_en = (fsm_reg == ST_ROUND) && !ph_reg;

`ifdef INVSBOX_FLUSH_EN
  assign gadget_clr = (fsm_reg == ST_DONE) && out_ready;
  assign out_data   = out_valid ? state_reg : '0;
`else
  assign gadget_clr = 1'b0;
  assign out_data   = state_reg;
`endif

  skinny_inv_sbox_round #(.d(d)) u_round (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (gadget_en),
    .clr      (gadget_clr),
    .state_in (state_reg),
    .rnd      (rnd),
    .state_out(round_out)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fsm_reg   <= ST_IDLE;
      rc_reg    <= 2'd0;
      ph_reg    <= 1'b0;
      state_reg <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (fsm_reg)
        ST_IDLE: begin
          if (in_valid) begin
            state_reg <= in_perm;
            rc_reg    <= 2'd3;
            ph_reg    <= 1'b0;
            fsm_reg   <= ST_ROUND;
            in_ready  <= 1'b0;
            busy      <= 1'b1;
          end
        end
        ST_ROUND: begin
          if (!ph_reg) begin
            ph_reg <= 1'b1;
          end else if (rc_reg != 2'd0) begin
            // Fold the next round's inverse permutation into this update.
            state_reg <= round_perm;
            rc_reg    <= rc_reg - 2'd1;
            ph_reg    <= 1'b0;
          end else begin
            state_reg <= round_out;
            ph_reg    <= 1'b0;
            fsm_reg   <= ST_DONE;
            busy      <= 1'b0;
            out_valid <= 1'b1;
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            fsm_reg   <= ST_IDLE;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
`ifdef INVSBOX_FLUSH_EN
            state_reg <= '0;
`endif
          end
        end
        default: begin
          fsm_reg   <= ST_IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_skinny_masked_inv_sbox_iterative.sv
// Randomized scoreboard bench for the masked inverse SKINNY S-box against a
// behavioural S8 model (inverse table built by inverting the forward box).
module tb_skinny_masked_inv_sbox_iterative;
  localparam int D  = 2;
  localparam int NR = 2 * (D * (D - 1) / 2);

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [8*D-1:0]  in_data = '0;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic [NR-1:0]   rnd = '0;
  logic [8*D-1:0]  out_data;
  logic            out_valid;
  logic            out_ready = 1'b0;
  logic            busy;

  int total = 0;
  int bad = 0;
  int txn = 0;
  logic [7:0] exp_q[$];
  logic [7:0] inv_tab[256];
  logic [8*D-1:0] last_out = '0;
  logic ready_rand = 1'b0;
  logic ready_force = 1'b1;

  skinny_masked_inv_sbox_iterative #(.d(D)) dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .rnd(rnd), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .busy(busy)
  );

  always #5 clk = ~clk;

  // Fresh randomness every cycle; consumer readiness fixed or random.
  always @(posedge clk) begin
    #1;
    rnd = NR'($urandom());
    out_ready = ready_rand ? 1'($urandom_range(0, 1)) : ready_force;
  end

  function automatic logic [7:0] s8(input logic [7:0] x);
    logic [7:0] y;
    y = x;
    for (int r = 0; r < 4; r++) begin
      y[4] = y[4] ^ ~(y[7] | y[6]);
      y[0] = y[0] ^ ~(y[3] | y[2]);
      if (r < 3) y = {y[2], y[1], y[7], y[6], y[4], y[0], y[3], y[5]};
      else       y = {y[7:3], y[1], y[2], y[0]};
    end
    return y;
  endfunction

  function automatic logic [8*D-1:0] mask(input logic [7:0] b);
    logic [8*D-1:0] v;
    for (int i = 0; i < 8; i++) begin
      logic [D-1:0] s;
      s = D'($urandom());
      s[0] = s[0] ^ (^s) ^ b[i];
      v[i*D +: D] = s;
    end
    return v;
  endfunction

  function automatic logic [7:0] unmask(input logic [8*D-1:0] v);
    logic [7:0] y;
    for (int i = 0; i < 8; i++) y[i] = ^v[i*D +: D];
    return y;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every accepted output is popped and compared.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        chk("spurious_out_valid", 32'(out_valid), 32'd0);
      end else begin
        logic [7:0] e;
        logic [7:0] got;
        e = exp_q.pop_front();
        got = unmask(out_data);
        last_out = out_data;
        txn++;
        $display("txn %0d: out=%02h expected=%02h", txn, got, e);
        chk("sbox_inv_result", 32'(got), 32'(e));
      end
    end
  end

  task automatic send(input logic [7:0] b, input logic [7:0] e);
    int n;
    n = 0;
    while (!in_ready && n < 300) begin
      @(posedge clk); #1;
      n++;
    end
    if (!in_ready) chk("in_ready_timeout", 32'(in_ready), 32'd1);
    in_data = mask(b);
    in_valid = 1'b1;
    exp_q.push_back(e);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0) chk("drain_timeout", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    logic [8*D-1:0] held;
    int n;
    for (int x = 0; x < 256; x++) inv_tab[s8(8'(x))] = 8'(x);

    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    chk("reset_in_ready", 32'(in_ready), 32'd1);
    chk("reset_out_valid", 32'(out_valid), 32'd0);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_out_data", 32'(out_data), 32'd0);

    // Latency and single-cycle out_valid with out_ready held high.
    send(8'h65, 8'h00);
    chk("busy_after_accept", 32'(busy), 32'd1);
    for (int k = 1; k <= 10; k++) begin
      @(posedge clk); #1;
      chk($sformatf("lat_out_valid_c%0d", k), 32'(out_valid), 32'(k == 8));
      chk($sformatf("lat_in_ready_c%0d", k), 32'(in_ready), 32'(k >= 9));
      chk($sformatf("lat_busy_c%0d", k), 32'(busy), 32'(k < 8));
    end

    send(8'h4C, 8'h01);
    send(8'hFF, 8'hFF);
    wait_drain();

    // Back-pressure: result must hold while out_ready is low.
    ready_force = 1'b0;
    send(8'h4C, 8'h01);
    n = 0;
    while (!out_valid && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    chk("hold_reached_done", 32'(out_valid), 32'd1);
    held = out_data;
    for (int k = 0; k < 20; k++) begin
      in_valid = 1'b1;
      in_data = mask(8'hAA);
      @(posedge clk); #1;
      chk("hold_out_valid", 32'(out_valid), 32'd1);
      chk("hold_out_data", 32'(out_data), 32'(held));
      chk("hold_in_ready", 32'(in_ready), 32'd0);
    end
    in_valid = 1'b0;
    ready_force = 1'b1;
    @(posedge clk);
    @(posedge clk); #1;
    chk("release_in_ready", 32'(in_ready), 32'd1);
    chk("release_out_valid", 32'(out_valid), 32'd0);

    // Reset in round rc=1, ph=1 discards the partial result.
    send(8'h65, 8'h00);
    repeat (5) @(posedge clk);
    #1 rst_n = 1'b0;
    void'(exp_q.pop_back());
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk("midrst_in_ready", 32'(in_ready), 32'd1);
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_out_data", 32'(out_data), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    repeat (10) @(posedge clk);
    #1;
    send(8'h65, 8'h00);
    wait_drain();

    // Post-handshake contents of out_data in IDLE.
    @(posedge clk); #1;
    chk("idle_in_ready", 32'(in_ready), 32'd1);
`ifdef INVSBOX_FLUSH_EN
    chk("flush_out_data", 32'(out_data), 32'd0);
`else
    chk("retain_out_data", 32'(out_data), 32'(last_out));
`endif

    // Exhaustive sweep with fresh sharings.
    for (int b = 0; b < 256; b++) send(8'(b), inv_tab[b]);
    wait_drain();

    // Round trip from the forward S-box output, random consumer readiness.
    ready_rand = 1'b1;
    for (int b = 0; b < 256; b++) send(s8(8'(b)), 8'(b));
    wait_drain();
    ready_rand = 1'b0;
    repeat (5) @(posedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
